// File: rtl/jtframe_ioctl_upload.sv
// Upload read path: serves ioctl_din bytes from SDRAM through the prog_* read handshake.
// Holds the current word (CUR) and one prefetched word (NXT) so sequential reads do not stall.
module jtframe_ioctl_upload #(
   parameter int                SDRAMW = 22,
   parameter logic [1:0]        BA     = 2'd0,
   parameter logic [SDRAMW-1:0] OFFSET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ioctl_ram,
   input  logic [24:0]       ioctl_addr,
   input  logic              ioctl_rd,
   output logic [7:0]        ioctl_din,
   output logic              din_ok,
   output logic [SDRAMW-1:0] prog_addr,
   output logic [1:0]        prog_ba,
   output logic              prog_rd,
   input  logic              prog_ack,
   input  logic              prog_rdy,
   input  logic [15:0]       sdram_dout
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

   state_t            st_q, st_d;
   logic              cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
   logic [SDRAMW-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
   logic [15:0]       cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;
   logic [SDRAMW-1:0] addr_q, addr_d;
   logic              pf_q, pf_d, drop_q, drop_d;
   logic [7:0]        din_q, din_d;
   logic              ok_q, ok_d;
   logic [SDRAMW-1:0] req_word, cur_succ;
   logic              cur_hit, nxt_hit, capture, keep, promote;
   logic              unused_ok;

   // ioctl_rd carries no information beyond the address change that follows it
   assign unused_ok = ^{ioctl_rd, ioctl_addr[24:SDRAMW+1]};

   assign req_word = OFFSET + ioctl_addr[SDRAMW:1];
   assign cur_succ = cur_tag_q + SDRAMW'(1);
   assign cur_hit  = cur_v_q && (cur_tag_q == req_word);
   assign nxt_hit  = nxt_v_q && (nxt_tag_q == req_word);
   assign capture  = (st_q == StWait) && prog_rdy;
   assign keep     = capture && ioctl_ram && !drop_q;
   // A demand capture into CUR wins; the promotion is retried on the next cycle
   assign promote  = ioctl_ram && !cur_hit && nxt_hit && !(keep && !pf_q);

   assign ioctl_din = din_q;
   assign din_ok    = ok_q;
   assign prog_addr = addr_q;
   assign prog_rd   = (st_q == StReq);
   assign prog_ba   = BA;

   always_comb begin
      st_d       = st_q;
      addr_d     = addr_q;
      pf_d       = pf_q;
      drop_d     = drop_q;
      cur_v_d    = cur_v_q;
      cur_tag_d  = cur_tag_q;
      cur_data_d = cur_data_q;
      nxt_v_d    = nxt_v_q;
      nxt_tag_d  = nxt_tag_q;
      nxt_data_d = nxt_data_q;
      din_d      = din_q;
      ok_d       = 1'b0;

      if (ioctl_ram && cur_hit) begin
         ok_d  = 1'b1;
         din_d = ioctl_addr[0] ? cur_data_q[15:8] : cur_data_q[7:0];
      end else if (ioctl_ram && nxt_hit) begin
         ok_d  = 1'b1;
         din_d = ioctl_addr[0] ? nxt_data_q[15:8] : nxt_data_q[7:0];
      end

      if (keep) begin
         if (pf_q) begin
            nxt_v_d    = 1'b1;
            nxt_tag_d  = addr_q;
            nxt_data_d = sdram_dout;
         end else begin
            cur_v_d    = 1'b1;
            cur_tag_d  = addr_q;
            cur_data_d = sdram_dout;
         end
      end

      if (promote) begin
         cur_v_d    = 1'b1;
         cur_tag_d  = nxt_tag_q;
         cur_data_d = nxt_data_q;
         if (!keep) nxt_v_d = 1'b0;
      end

      if (!ioctl_ram) begin
         cur_v_d = 1'b0;
         nxt_v_d = 1'b0;
      end

      // Data from an access that straddled a window close must never become valid
      if (capture) drop_d = 1'b0;
      else if (!ioctl_ram && st_q != StIdle) drop_d = 1'b1;

      unique case (st_q)
         StIdle: begin
            if (ioctl_ram) begin
               if (!cur_hit && !nxt_hit) begin
                  addr_d = req_word;
                  pf_d   = 1'b0;
                  st_d   = StReq;
               end else if (cur_hit && (!nxt_v_q || nxt_tag_q != cur_succ)) begin
                  addr_d = cur_succ;
                  pf_d   = 1'b1;
                  st_d   = StReq;
               end
            end
         end
         StReq:   if (prog_ack) st_d = StWait;
         StWait:  if (prog_rdy) st_d = StIdle;
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= StIdle;
         addr_q     <= '0;
         pf_q       <= 1'b0;
         drop_q     <= 1'b0;
         cur_v_q    <= 1'b0;
         cur_tag_q  <= '0;
         cur_data_q <= '0;
         nxt_v_q    <= 1'b0;
         nxt_tag_q  <= '0;
         nxt_data_q <= '0;
         din_q      <= '0;
         ok_q       <= 1'b0;
      end else begin
         st_q       <= st_d;
         addr_q     <= addr_d;
         pf_q       <= pf_d;
         drop_q     <= drop_d;
         cur_v_q    <= cur_v_d;
         cur_tag_q  <= cur_tag_d;
         cur_data_q <= cur_data_d;
         nxt_v_q    <= nxt_v_d;
         nxt_tag_q  <= nxt_tag_d;
         nxt_data_q <= nxt_data_d;
         din_q      <= din_d;
         ok_q       <= ok_d;
      end
   end

endmodule

// File: tb/tb_jtframe_ioctl_upload.sv
// Bench for jtframe_ioctl_upload: SDRAM responder model plus a byte-level reference built from
// a word array, with directed scenarios and a randomized read walk.
module tb_jtframe_ioctl_upload;

   logic        clk = 1'b0;
   logic        rst;
   logic        ioctl_ram, ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        din_ok;
   logic [21:0] prog_addr;
   logic [1:0]  prog_ba;
   logic        prog_rd, prog_ack, prog_rdy;
   logic [15:0] sdram_dout;

   logic        o_ram, o_ack, o_rdy;
   logic [24:0] o_addr;
   logic [7:0]  o_din;
   logic        o_ok, o_rd;
   logic [21:0] o_paddr;
   logic [1:0]  o_ba;
   logic [15:0] o_dout;

   logic [15:0] mem [0:4095];
   logic [21:0] fetch_q [$];
   int          errors = 0, checks = 0;
   int          n_req = 0, ack_delay = 0, rdy_delay = 1;
   bit          rand_lat = 1'b0, busy = 1'b0;

   always #5 clk = ~clk;

   jtframe_ioctl_upload #(.SDRAMW(22), .BA(2'd2), .OFFSET(22'd0)) u_dut (
      .clk(clk), .rst(rst), .ioctl_ram(ioctl_ram), .ioctl_addr(ioctl_addr),
      .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din), .din_ok(din_ok), .prog_addr(prog_addr),
      .prog_ba(prog_ba), .prog_rd(prog_rd), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
      .sdram_dout(sdram_dout)
   );

   jtframe_ioctl_upload #(.SDRAMW(22), .BA(2'd1), .OFFSET(22'h3FFFFF)) u_off (
      .clk(clk), .rst(rst), .ioctl_ram(o_ram), .ioctl_addr(o_addr),
      .ioctl_rd(1'b0), .ioctl_din(o_din), .din_ok(o_ok), .prog_addr(o_paddr),
      .prog_ba(o_ba), .prog_rd(o_rd), .prog_ack(o_ack), .prog_rdy(o_rdy),
      .sdram_dout(o_dout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_byte(input int a);
      logic [15:0] w;
      w = mem[(a >> 1) & 4095];
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   function automatic int fetch_count(input logic [21:0] w);
      int c = 0;
      foreach (fetch_q[i]) if (fetch_q[i] == w) c++;
      return c;
   endfunction

   // SDRAM controller model: accepts one request at a time, logs each accepted word address
   initial begin : sdram_model
      logic [21:0] a;
      int ad, rl;
      prog_ack = 1'b0;
      prog_rdy = 1'b0;
      sdram_dout = '0;
      forever begin
         tick();
         if (prog_rd && !rst) begin
            a = prog_addr;
            busy = 1'b1;
            n_req++;
            ad = rand_lat ? int'($urandom_range(3, 0)) : ack_delay;
            rl = rand_lat ? int'($urandom_range(3, 0)) : rdy_delay;
            check("prog_ba", prog_ba, 2);
            for (int i = 0; i < ad; i++) begin
               tick();
               check("req_hold", {prog_rd, prog_addr}, {1'b1, a});
            end
            prog_ack = 1'b1;
            tick();
            prog_ack = 1'b0;
            check("rd_after_ack", prog_rd, 0);
            fetch_q.push_back(a);
            repeat (rl) tick();
            prog_rdy = 1'b1;
            sdram_dout = mem[a[11:0]];
            tick();
            prog_rdy = 1'b0;
            busy = 1'b0;
         end
      end
   end

   task automatic wait_ok(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!din_ok && n < 200);
      check({tag, "_ok"}, din_ok, 1);
   endtask

   task automatic read_byte(input string tag, input int a);
      ioctl_addr = 25'(a);
      wait_ok(tag);
      check({tag, "_byte"}, ioctl_din, exp_byte(a));
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         tick();
         n++;
      end while ((busy || prog_rd) && n < 200);
      check("drain", busy, 0);
   endtask

   task automatic restart();
      ioctl_ram = 1'b0;
      tick();
      wait_idle();
      fetch_q.delete();
      tick();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int a, n, n0;
      rst = 1'b1;
      ioctl_ram = 1'b0;
      ioctl_addr = '0;
      ioctl_rd = 1'b0;
      o_ram = 1'b0;
      o_addr = '0;
      o_ack = 1'b0;
      o_rdy = 1'b0;
      o_dout = '0;
      for (int k = 0; k < 4096; k++) mem[k] = 16'($urandom);
      for (int k = 0; k < 8; k++) mem[k] = 16'(k * 16'h1101);
      mem[0] = 16'hA55A;
      repeat (3) tick();
      check("rst_din", ioctl_din, 0);
      check("rst_ok", din_ok, 0);
      check("rst_rd", prog_rd, 0);
      check("rst_addr", prog_addr, 0);

      // First access after reset is a demand fetch of word 0
      rst = 1'b0;
      ioctl_ram = 1'b1;
      ioctl_addr = '0;
      tick();
      check("t1_rd", prog_rd, 1);
      check("t1_paddr", prog_addr, 0);
      wait_ok("t1_a0");
      check("t1_a0_byte", ioctl_din, 8'h5A);
      ioctl_addr = 25'd1;
      wait_ok("t1_a1");
      check("t1_a1_byte", ioctl_din, 8'hA5);
      repeat (5) tick();
      check("t1_w0_once", fetch_count(22'd0), 1);

      // Sequential bytes 0..7: words 0..3 demanded/prefetched once, then prefetch of word 4
      restart();
      mem[0] = 16'h0000;
      ioctl_ram = 1'b1;
      for (int k = 0; k < 8; k++) read_byte("seq", k);
      repeat (10) tick();
      for (int k = 0; k < 5; k++) check("seq_fetch_once", fetch_count(22'(k)), 1);
      check("seq_fetch_total", fetch_q.size(), 5);
      ioctl_ram = 1'b0;
      tick();
      check("seq_ram_drop_ok", din_ok, 0);

      // Address jump while the prefetch of word 1 is in its WAIT phase
      restart();
      rdy_delay = 4;
      ioctl_ram = 1'b1;
      read_byte("jmp0", 0);
      n = 0;
      while (fetch_q.size() < 2 && n < 50) begin
         tick();
         n++;
      end
      check("jmp_wait_w1", fetch_q.size(), 2);
      ioctl_addr = 25'h1234;
      tick();
      check("jmp_ok_low", din_ok, 0);
      n = 0;
      while (!din_ok && n < 100) begin
         tick();
         n++;
      end
      check("jmp_ok", din_ok, 1);
      check("jmp_byte", ioctl_din, exp_byte(32'h1234));
      check("jmp_w1_done", fetch_q[1], 1);
      check("jmp_w91a", fetch_q[2], 22'h91A);
      rdy_delay = 1;

      // Slow acknowledge: request must hold for all 20 cycles without repeating
      restart();
      ack_delay = 20;
      ioctl_ram = 1'b1;
      read_byte("slow", 32'h100);
      check("slow_fetches", fetch_q.size(), 1);
      check("slow_word", fetch_q[0], 22'h80);
      ack_delay = 0;

      // Window closes during WAIT: data discarded, no new requests while closed
      restart();
      rdy_delay = 5;
      ioctl_ram = 1'b1;
      ioctl_addr = 25'h40;
      n = 0;
      while (fetch_q.size() < 1 && n < 50) begin
         tick();
         n++;
      end
      ioctl_ram = 1'b0;
      wait_idle();
      check("drop_ok", din_ok, 0);
      check("drop_rd", prog_rd, 0);
      n0 = n_req;
      repeat (10) tick();
      check("drop_no_req", n_req, n0);
      ioctl_ram = 1'b1;
      wait_ok("drop_reopen");
      check("drop_reopen_byte", ioctl_din, exp_byte(32'h40));
      check("drop_refetch", fetch_q.size(), 2);
      check("drop_refetch_w", fetch_q[1], 22'h20);
      rdy_delay = 1;

      // Randomized walk: mostly sequential with occasional jumps, random SDRAM latency
      restart();
      rand_lat = 1'b1;
      ioctl_ram = 1'b1;
      a = 0;
      for (int k = 0; k < 80; k++) begin
         read_byte("rnd", a);
         a = ($urandom_range(3, 0) == 0) ? int'($urandom_range(8191, 0)) : ((a + 1) & 8191);
      end
      rand_lat = 1'b0;

      // Offset wraps past the top of the SDRAM word space
      o_ram = 1'b1;
      o_addr = 25'd2;
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_rd && n < 20);
      check("off_rd", o_rd, 1);
      check("off_paddr", o_paddr, 0);
      check("off_ba", o_ba, 1);
      o_ack = 1'b1;
      tick();
      o_ack = 1'b0;
      tick();
      o_rdy = 1'b1;
      o_dout = 16'hBEEF;
      tick();
      o_rdy = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_ok && n < 10);
      check("off_ok", o_ok, 1);
      check("off_byte_lo", o_din, 8'hEF);
      o_addr = 25'd3;
      tick();
      check("off_byte_hi", o_din, 8'hBE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
